// File: rtl/tank_pkg.sv
// Shared definitions for the tank game: key/direction codes, screen limits,
// bullet FSM states and the saturating position-step helper.
package tank_pkg;

  localparam logic [7:0] KEY_ENTER    = 8'h58;
  localparam logic [9:0] SCREEN_X_MAX = 10'd639;
  localparam logic [9:0] SCREEN_Y_MAX = 10'd479;
  localparam logic [9:0] TANK_SIZE    = 10'd32;

  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_DOWN  = 3'd4;

  localparam logic [1:0] HIT1_NONE = 2'b00;
  localparam logic [1:0] HIT1_FLY  = 2'b01;
  localparam logic [1:0] HIT1_WALL = 2'b10;

  typedef enum logic [1:0] {
    BS_IDLE     = 2'd0,
    BS_FLYING   = 2'd1,
    BS_HIT      = 2'd2,
    BS_COOLDOWN = 2'd3
  } bullet_state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       hit;
  } pos_res_t;

  function automatic logic dir_valid(input logic [2:0] d);
    return (d >= DIR_UP) && (d <= DIR_DOWN);
  endfunction

  // Moves pos by delta (subtract when neg) in 11-bit arithmetic; results below 0
  // or above hi (largest legal top-left) saturate and flag a wall hit.
  function automatic pos_res_t step_pos(input logic [9:0] pos, input logic [9:0] delta,
                                        input logic neg, input logic [9:0] hi);
    pos_res_t    r;
    logic [10:0] res;
    res = neg ? ({1'b0, pos} - {1'b0, delta}) : ({1'b0, pos} + {1'b0, delta});
    r   = '{pos: res[9:0], hit: 1'b0};
    if (neg && (pos < delta)) r = '{pos: 10'd0, hit: 1'b1};
    else if (res > {1'b0, hi}) r = '{pos: hi, hit: 1'b1};
    return r;
  endfunction

endpackage

// File: rtl/bullet_ctrl_if.sv
// Bundle between the game logic (master) and the bullet controller (slave).
interface bullet_ctrl_if;
  import tank_pkg::*;

  logic [7:0]    keycode;
  logic [9:0]    tank_X;
  logic [9:0]    tank_Y;
  logic [2:0]    tank_dir;
  logic [9:0]    DrawX;
  logic [9:0]    DrawY;
  logic          is_bullet;
  logic [9:0]    bullet_X;
  logic [9:0]    bullet_Y;
  logic [1:0]    hit1;
  logic          fire_ack;
  bullet_state_t dbg_state;

  // fire_ack is a single-Clk strobe with no ready: it marks the launch of a
  // shot and the master must not stall it; requests are never queued.
  modport master (output keycode, tank_X, tank_Y, tank_dir, DrawX, DrawY,
                  input  is_bullet, bullet_X, bullet_Y, hit1, fire_ack, dbg_state);
  modport slave  (input  keycode, tank_X, tank_Y, tank_dir, DrawX, DrawY,
                  output is_bullet, bullet_X, bullet_Y, hit1, fire_ack, dbg_state);
endinterface

// File: rtl/frame_tick.sv
// Rising-edge detector for the slow frame clock, producing a one-Clk tick.
module frame_tick (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_frame_clk,
  output logic o_tick
);
  logic r_meta;
  logic r_prev;
  logic r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_meta <= i_frame_clk;
      r_prev <= r_meta;
      r_tick <= r_meta & ~r_prev;
    end
  end

  assign o_tick = r_tick;
endmodule

// File: rtl/bullet_ctrl.sv
// Single-bullet controller: launches on Enter, flies one step per frame,
// saturates at screen edges, then holds a cooldown before the next shot.
module bullet_ctrl
  import tank_pkg::*;
#(
  parameter logic [9:0] Bullet_Size     = 10'd8,
  parameter logic [9:0] Bullet_Step     = 10'd4,
  parameter logic [5:0] Cooldown_Frames = 6'd15,
  parameter logic [9:0] X_Max           = SCREEN_X_MAX,
  parameter logic [9:0] Y_Max           = SCREEN_Y_MAX
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_clk,
  bullet_ctrl_if.slave bus
);
   localparam logic [9:0] X_HI     = X_Max - Bullet_Size + 10'd1;
   localparam logic [9:0] Y_HI     = Y_Max - Bullet_Size + 10'd1;
   localparam logic [9:0] SIDE_OFS = (TANK_SIZE - Bullet_Size) >> 1;

   bullet_state_t r_state, w_state_nxt;
   logic [9:0]    r_x, r_y, w_x_nxt, w_y_nxt;
   logic [2:0]    r_dir, w_dir_nxt;
   logic [5:0]    r_cnt, w_cnt_nxt;
   logic          r_req, w_req_nxt;
   logic          r_enter_prev, r_fire_ack, w_launch;
   logic [1:0]    r_hit1, w_hit1_nxt;
   logic          w_tick, w_press;
   pos_res_t      w_sp_x, w_sp_y, w_mv_x, w_mv_y;

   frame_tick u_frame_tick (
      .i_clk       (Clk),
      .i_rst_n     (Reset_n),
      .i_frame_clk (frame_clk),
      .o_tick      (w_tick)
   );

   // Reset treats Enter as already held, so a key held through reset cannot fire.
   assign w_press = (bus.keycode == KEY_ENTER) && !r_enter_prev;

   always_comb begin
      w_sp_x = step_pos(bus.tank_X, SIDE_OFS, 1'b0, X_HI);
      w_sp_y = step_pos(bus.tank_Y, SIDE_OFS, 1'b0, Y_HI);
      case (bus.tank_dir)
         DIR_UP:    w_sp_y = step_pos(bus.tank_Y, Bullet_Size, 1'b1, Y_HI);
         DIR_DOWN:  w_sp_y = step_pos(bus.tank_Y, TANK_SIZE,   1'b0, Y_HI);
         DIR_LEFT:  w_sp_x = step_pos(bus.tank_X, Bullet_Size, 1'b1, X_HI);
         DIR_RIGHT: w_sp_x = step_pos(bus.tank_X, TANK_SIZE,   1'b0, X_HI);
         default:   ;
      endcase
   end

   always_comb begin
      w_mv_x = '{pos: r_x, hit: 1'b0};
      w_mv_y = '{pos: r_y, hit: 1'b0};
      case (r_dir)
         DIR_UP:    w_mv_y = step_pos(r_y, Bullet_Step, 1'b1, Y_HI);
         DIR_DOWN:  w_mv_y = step_pos(r_y, Bullet_Step, 1'b0, Y_HI);
         DIR_LEFT:  w_mv_x = step_pos(r_x, Bullet_Step, 1'b1, X_HI);
         DIR_RIGHT: w_mv_x = step_pos(r_x, Bullet_Step, 1'b0, X_HI);
         default:   ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_dir_nxt   = r_dir;
      w_cnt_nxt   = r_cnt;
      w_req_nxt   = 1'b0;
      w_launch    = 1'b0;
      case (r_state)
         BS_IDLE: begin
            w_req_nxt = r_req | w_press;
            if (w_tick && r_req) begin
               w_req_nxt = w_press;
               if (dir_valid(bus.tank_dir)) begin
                  w_launch    = 1'b1;
                  w_dir_nxt   = bus.tank_dir;
                  w_x_nxt     = w_sp_x.pos;
                  w_y_nxt     = w_sp_y.pos;
                  w_state_nxt = (w_sp_x.hit || w_sp_y.hit) ? BS_HIT : BS_FLYING;
               end
            end
         end
         BS_FLYING: if (w_tick) begin
            w_x_nxt = w_mv_x.pos;
            w_y_nxt = w_mv_y.pos;
            if (w_mv_x.hit || w_mv_y.hit) w_state_nxt = BS_HIT;
         end
         BS_HIT: if (w_tick) begin
            w_state_nxt = BS_COOLDOWN;
            w_cnt_nxt   = Cooldown_Frames;
         end
         BS_COOLDOWN: if (w_tick) begin
            // A load of 0 behaves like 1: leave on the first tick.
            if (r_cnt <= 6'd1) begin
               w_state_nxt = BS_IDLE;
               w_cnt_nxt   = 6'd0;
            end else begin
               w_cnt_nxt = r_cnt - 6'd1;
            end
         end
         default: w_state_nxt = BS_IDLE;
      endcase
      case (w_state_nxt)
         BS_FLYING: w_hit1_nxt = HIT1_FLY;
         BS_HIT:    w_hit1_nxt = HIT1_WALL;
         default:   w_hit1_nxt = HIT1_NONE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state      <= BS_IDLE;
         r_x          <= 10'd0;
         r_y          <= 10'd0;
         r_dir        <= 3'd0;
         r_cnt        <= 6'd0;
         r_req        <= 1'b0;
         r_enter_prev <= 1'b1;
         r_fire_ack   <= 1'b0;
         r_hit1       <= HIT1_NONE;
      end else begin
         r_state      <= w_state_nxt;
         r_x          <= w_x_nxt;
         r_y          <= w_y_nxt;
         r_dir        <= w_dir_nxt;
         r_cnt        <= w_cnt_nxt;
         r_req        <= w_req_nxt;
         r_enter_prev <= (bus.keycode == KEY_ENTER);
         r_fire_ack   <= w_launch;
         r_hit1       <= w_hit1_nxt;
      end
   end

   assign bus.is_bullet = (r_state == BS_FLYING) &&
                          ({1'b0, bus.DrawX} >= {1'b0, r_x}) &&
                          ({1'b0, bus.DrawX} <  ({1'b0, r_x} + {1'b0, Bullet_Size})) &&
                          ({1'b0, bus.DrawY} >= {1'b0, r_y}) &&
                          ({1'b0, bus.DrawY} <  ({1'b0, r_y} + {1'b0, Bullet_Size}));
   assign bus.bullet_X  = r_x;
   assign bus.bullet_Y  = r_y;
   assign bus.hit1      = r_hit1;
   assign bus.fire_ack  = r_fire_ack;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: directed scenarios plus random shots, checked per frame
// against a coordinate-level model of the bullet rules.
module tb_bullet_ctrl;
  localparam int BS    = 8;
  localparam int STEP  = 4;
  localparam int CF    = 15;
  localparam int X_TOP = 639 - BS + 1;
  localparam int Y_TOP = 479 - BS + 1;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_clk = 1'b0;
  always #10 Clk = ~Clk;

  bullet_ctrl_if bif();

  bullet_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bif.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int ack_exp = 0;

  always @(negedge Clk) if (bif.fire_ack === 1'b1) ack_cnt++;

  initial begin
    #1_500_000;
    $display("FAIL timeout: run exceeded time limit, got %0d vectors, required completion", n_vec);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // mode: 0 no bullet, 1 flying, 2 at wall, 3 waiting to re-arm
  int mode, m_x, m_y, m_dx, m_dy, cool_left;
  bit m_req;
  int cur_tx, cur_ty, cur_dir;

  task automatic m_reset();
    mode = 0; m_x = 0; m_y = 0; m_req = 0; cool_left = 0;
  endtask

  function automatic bit m_clamp();
    bit hit = 0;
    if (m_x < 0)     begin m_x = 0;     hit = 1; end
    if (m_x > X_TOP) begin m_x = X_TOP; hit = 1; end
    if (m_y < 0)     begin m_y = 0;     hit = 1; end
    if (m_y > Y_TOP) begin m_y = Y_TOP; hit = 1; end
    return hit;
  endfunction

  task automatic m_press();
    if (mode == 0) m_req = 1;
  endtask

  task automatic m_tick();
    int ofs = (32 - BS) / 2;
    case (mode)
      0: if (m_req) begin
        m_req = 0;
        if (cur_dir >= 1 && cur_dir <= 4) begin
          ack_exp++;
          m_dx = (cur_dir == 2) ? 1 : (cur_dir == 3) ? -1 : 0;
          m_dy = (cur_dir == 4) ? 1 : (cur_dir == 1) ? -1 : 0;
          m_x = (m_dx == 0) ? cur_tx + ofs : (m_dx > 0) ? cur_tx + 32 : cur_tx - BS;
          m_y = (m_dy == 0) ? cur_ty + ofs : (m_dy > 0) ? cur_ty + 32 : cur_ty - BS;
          mode = m_clamp() ? 2 : 1;
        end
      end
      1: begin
        m_x += m_dx * STEP;
        m_y += m_dy * STEP;
        if (m_clamp()) mode = 2;
      end
      2: begin mode = 3; cool_left = CF; end
      default: begin
        if (cool_left > 0) cool_left--;
        if (cool_left == 0) mode = 0;
      end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit exp_on_bullet(input int px, input int py);
    return (mode == 1) && px >= m_x && px < m_x + BS && py >= m_y && py < m_y + BS;
  endfunction

  task automatic check_state(input string tag);
    int px = m_x + int'($urandom_range(0, 11)) - 2;
    int py = m_y + int'($urandom_range(0, 11)) - 2;
    if (px < 0) px = 0;
    if (py < 0) py = 0;
    bif.DrawX = px[9:0];
    bif.DrawY = py[9:0];
    #1;
    check({tag, "_x"},    32'(bif.bullet_X), m_x);
    check({tag, "_y"},    32'(bif.bullet_Y), m_y);
    check({tag, "_hit1"}, 32'(bif.hit1), (mode == 1) ? 1 : (mode == 2) ? 2 : 0);
    check({tag, "_acks"}, ack_cnt, ack_exp);
    check({tag, "_isb"},  32'(bif.is_bullet), 32'(exp_on_bullet(px, py)));
  endtask

  // ---------------- drivers ----------------
  task automatic set_tank(input int x, input int y, input int d);
    cur_tx = x; cur_ty = y; cur_dir = d;
    bif.tank_X = x[9:0]; bif.tank_Y = y[9:0]; bif.tank_dir = d[2:0];
  endtask

  task automatic do_frame(input string tag);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    m_tick();
    check_state(tag);
  endtask

  task automatic press_enter();
    @(negedge Clk) bif.keycode = 8'h58;
    m_press();
    repeat (2) @(negedge Clk);
    bif.keycode = 8'h00;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0; frame_clk = 1'b0; bif.keycode = 8'h00;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    m_reset();
    @(negedge Clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bif.keycode = 8'h00; bif.DrawX = '0; bif.DrawY = '0;
    set_tank(100, 200, 2);
    m_reset();
    do_reset();
    check_state("reset");

    // right shot from (100,200)
    press_enter();
    do_frame("right_launch");
    do_frame("right_step");

    // upward shot to the top wall, then cooldown with repeated presses
    do_reset();
    set_tank(300, 20, 1);
    press_enter();
    for (int i = 0; i < 5; i++) do_frame("up_wall");
    for (int i = 0; i < 18; i++) begin
      press_enter();
      do_frame("cooldown");
    end

    // Enter held for 10 ticks, then a press during cooldown
    do_reset();
    set_tank(600, 240, 2);
    @(negedge Clk) bif.keycode = 8'h58;
    m_press();
    for (int i = 0; i < 10; i++) do_frame("held");
    bif.keycode = 8'h00;
    press_enter();
    for (int i = 0; i < 3; i++) do_frame("cool_press");

    // left shot at x=0 must saturate, never wrap
    do_reset();
    set_tank(0, 240, 3);
    press_enter();
    do_frame("left_edge");
    check("no_wrap", 32'(bif.bullet_X == 10'd1016), 0);

    // direction latched at launch
    do_reset();
    set_tank(100, 100, 2);
    press_enter();
    do_frame("steer_launch");
    set_tank(100, 100, 1);
    for (int i = 0; i < 3; i++) do_frame("steer");

    // invalid direction discards the request
    do_reset();
    set_tank(200, 200, 0);
    press_enter();
    do_frame("bad_dir");
    set_tank(200, 200, 4);
    do_frame("bad_dir_after");

    // asynchronous reset mid-flight, Enter held across reset
    do_reset();
    set_tank(100, 200, 2);
    press_enter();
    do_frame("pre_rst");
    do_frame("pre_rst");
    @(negedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    check("rst_x", 32'(bif.bullet_X), 0);
    check("rst_y", 32'(bif.bullet_Y), 0);
    check("rst_hit1", 32'(bif.hit1), 0);
    check("rst_ack", 32'(bif.fire_ack), 0);
    for (int i = 0; i < 24; i++) begin
      bif.DrawX = 10'(m_x - 4 + i); bif.DrawY = 10'(m_y - 4 + i);
      #1 check("rst_isb", 32'(bif.is_bullet), 0);
    end
    bif.keycode = 8'h58;
    m_reset();
    @(negedge Clk) Reset_n = 1'b1;
    do_frame("held_thru_rst");
    bif.keycode = 8'h00;
    press_enter();
    do_frame("fresh_press");

    // randomized shots
    do_reset();
    for (int s = 0; s < 80; s++) begin
      int tx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) * 620 : int'($urandom_range(0, 700));
      int ty = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) * 460 : int'($urandom_range(0, 500));
      set_tank(tx, ty, int'($urandom_range(0, 5)));
      if ($urandom_range(0, 2) != 0) press_enter();
      for (int f = int'($urandom_range(1, 12)); f > 0; f--) begin
        if ($urandom_range(0, 7) == 0) set_tank(tx, ty, int'($urandom_range(0, 5)));
        do_frame("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
